// File: rtl/galaksija_pkg.sv
// Shared types and constants for the Galaksija tape loader slice.
// Widths here must agree with the progress-bar inputs of galaksija_video.
package galaksija_pkg;

  localparam int TAPE_ADDR_W = 14;
  localparam logic [7:0] TAPE_EOF_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    FETCH = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } tape_state_t;

  function automatic logic is_active_state(input tape_state_t s);
    return (s == LOAD) || (s == READY) || (s == FETCH) || (s == WAIT);
  endfunction

endpackage

// File: rtl/galaksija_tape_loader_if.sv
// Host download, CPU tape-read and progress signals of the tape loader.
// The master side is the host/CPU; the slave side is the loader itself.
interface galaksija_tape_loader_if #(
  parameter int ADDR_W = galaksija_pkg::TAPE_ADDR_W
);

  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              rd_req;
  logic              rewind;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              eof;
  logic [ADDR_W-1:0] addr_max;
  logic [ADDR_W-1:0] read_counter;
  logic              download_active;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rd_req, rewind,
    input  rd_data, rd_valid, eof, addr_max, read_counter, download_active
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, rd_req, rewind,
    output rd_data, rd_valid, eof, addr_max, read_counter, download_active
  );

endinterface

// File: rtl/galaksija_tape_buffer.sv
// Tape image storage: simple dual-port RAM with a registered read port.
// Storage carries no reset so it maps onto block RAM.
module galaksija_tape_buffer #(
  parameter int ADDR_W = galaksija_pkg::TAPE_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/galaksija_tape_loader.sv
// Captures a host-downloaded tape image and replays it byte by byte to the
// CPU, while exporting addr_max/read_counter for the video progress bar.
module galaksija_tape_loader
  import galaksija_pkg::*;
#(
  parameter int         ADDR_W   = TAPE_ADDR_W,
  parameter logic [7:0] EOF_BYTE = TAPE_EOF_BYTE
) (
  input logic                  clk,
  input logic                  resetn,
  galaksija_tape_loader_if.slave bus
);

  tape_state_t state_q, state_d;

  logic              dl_q;
  logic              have_data_q;
  logic [ADDR_W-1:0] addr_max_q;
  logic [ADDR_W-1:0] read_counter_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              eof_q;
  logic              download_active_q;
  logic [1:0]        eof_pipe_q;

  logic              dl_rise;
  logic              dl_fall;
  logic              eof_busy;
  logic              last_byte;
  logic              wr_accept;
  logic              rd_accept;
  logic              eof_accept;
  logic              finish_read;
  logic              do_rewind;
  logic [7:0]        ram_q;

  assign dl_rise   = bus.ioctl_download & ~dl_q;
  assign dl_fall   = ~bus.ioctl_download & dl_q;
  assign eof_busy  = |eof_pipe_q;
  assign last_byte = (read_counter_q == addr_max_q);

  galaksija_tape_buffer #(
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk   (clk),
    .we    (wr_accept),
    .waddr (bus.ioctl_addr),
    .wdata (bus.ioctl_dout),
    .re    (rd_accept),
    .raddr (read_counter_q),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A new download window overrides everything, including a read in flight.
  always_comb begin
    state_d     = state_q;
    wr_accept   = 1'b0;
    rd_accept   = 1'b0;
    eof_accept  = 1'b0;
    finish_read = 1'b0;
    do_rewind   = 1'b0;
    if (dl_rise) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.rd_req && !eof_busy) begin
            eof_accept = 1'b1;
          end
        end
        LOAD: begin
          wr_accept = bus.ioctl_wr;
          if (dl_fall) begin
            state_d = (have_data_q || bus.ioctl_wr) ? READY : IDLE;
          end
        end
        READY: begin
          if (bus.rewind) begin
            do_rewind = 1'b1;
          end else if (bus.rd_req && !eof_busy) begin
            rd_accept = 1'b1;
            state_d   = FETCH;
          end
        end
        FETCH: begin
          state_d = WAIT;
        end
        WAIT: begin
          finish_read = 1'b1;
          state_d     = last_byte ? DONE : READY;
        end
        DONE: begin
          if (bus.rewind) begin
            do_rewind = 1'b1;
            state_d   = READY;
          end else if (bus.rd_req && !eof_busy) begin
            eof_accept = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // EOF replies travel a two-stage pipe so they match the RAM read latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dl_q              <= 1'b0;
      have_data_q       <= 1'b0;
      addr_max_q        <= '0;
      read_counter_q    <= '0;
      rd_data_q         <= 8'h00;
      rd_valid_q        <= 1'b0;
      eof_q             <= 1'b0;
      download_active_q <= 1'b0;
      eof_pipe_q        <= 2'b00;
    end else begin
      dl_q              <= bus.ioctl_download;
      rd_valid_q        <= 1'b0;
      download_active_q <= is_active_state(state_d);
      eof_pipe_q        <= {eof_pipe_q[0], eof_accept};
      if (dl_rise) begin
        have_data_q    <= 1'b0;
        addr_max_q     <= '0;
        read_counter_q <= '0;
        eof_q          <= 1'b0;
        eof_pipe_q     <= 2'b00;
      end else begin
        if (wr_accept) begin
          have_data_q <= 1'b1;
          if (bus.ioctl_addr > addr_max_q) begin
            addr_max_q <= bus.ioctl_addr;
          end
        end
        if (do_rewind) begin
          read_counter_q <= '0;
          eof_q          <= 1'b0;
        end
        if (finish_read) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= ram_q;
          if (last_byte) begin
            eof_q <= 1'b1;
          end else begin
            read_counter_q <= read_counter_q + ADDR_W'(1);
          end
        end
        if (eof_pipe_q[1]) begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= EOF_BYTE;
        end
      end
    end
  end

  assign bus.rd_data         = rd_data_q;
  assign bus.rd_valid        = rd_valid_q;
  assign bus.eof             = eof_q;
  assign bus.addr_max        = addr_max_q;
  assign bus.read_counter    = read_counter_q;
  assign bus.download_active = download_active_q;

endmodule

// File: tb/tb_galaksija_tape_loader.sv
// Directed bench for galaksija_tape_loader: load, playback, handshake,
// rewind, abort and reset scenarios with hand-computed expectations.
module tb_galaksija_tape_loader;
  import galaksija_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;
  int   valid_count;
  int   vc_before;

  galaksija_tape_loader_if #(.ADDR_W(14)) bus ();

  galaksija_tape_loader #(
    .ADDR_W   (14),
    .EOF_BYTE (8'h00)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) valid_count++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the download window writing 8'h11,22,.. at addresses 0..n-1.
  task automatic load_image(input int n);
    bus.ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < n; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 14'(i);
      bus.ioctl_dout = 8'((i + 1) * 8'h11);
      tick(1);
    end
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_download = 1'b0;
    tick(1);
  endtask

  // One rd_req pulse; result is sampled after the second edge following acceptance.
  task automatic read_byte(input string tag, input logic [7:0] exp_data,
                           input logic [13:0] exp_rc, input logic exp_eof);
    bus.rd_req = 1'b1;
    tick(1);
    bus.rd_req = 1'b0;
    check_output({tag, "_early"}, 32'(bus.rd_valid), 32'd0);
    tick(2);
    check_output({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check_output({tag, "_data"}, 32'(bus.rd_data), 32'(exp_data));
    check_output({tag, "_rc"}, 32'(bus.read_counter), 32'(exp_rc));
    check_output({tag, "_eof"}, 32'(bus.eof), 32'(exp_eof));
    tick(1);
    check_output({tag, "_pulse"}, 32'(bus.rd_valid), 32'd0);
  endtask

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    valid_count        = 0;
    resetn             = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;
    bus.rd_req         = 1'b0;
    bus.rewind         = 1'b0;
    tick(2);

    $display("[TB] reset state");
    check_output("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check_output("rst_eof", 32'(bus.eof), 32'd0);
    check_output("rst_addr_max", 32'(bus.addr_max), 32'd0);
    check_output("rst_rc", 32'(bus.read_counter), 32'd0);
    check_output("rst_active", 32'(bus.download_active), 32'd0);
    resetn = 1'b1;
    tick(1);

    $display("[TB] load four bytes");
    load_image(4);
    check_output("load_addr_max", 32'(bus.addr_max), 32'd3);
    check_output("load_state", 32'(dut.state_q), 32'(READY));
    check_output("load_active", 32'(bus.download_active), 32'd1);
    check_output("load_rc", 32'(bus.read_counter), 32'd0);

    $display("[TB] playback");
    read_byte("play0", 8'h11, 14'd1, 1'b0);
    read_byte("play1", 8'h22, 14'd2, 1'b0);
    read_byte("play2", 8'h33, 14'd3, 1'b0);
    read_byte("play3", 8'h44, 14'd3, 1'b1);
    check_output("play_done_active", 32'(bus.download_active), 32'd0);
    check_output("play_done_state", 32'(dut.state_q), 32'(DONE));
    read_byte("play_eof", 8'h00, 14'd3, 1'b1);
    check_output("play_eof_state", 32'(dut.state_q), 32'(DONE));

    $display("[TB] rewind");
    bus.rewind = 1'b1;
    tick(1);
    bus.rewind = 1'b0;
    check_output("rew_rc", 32'(bus.read_counter), 32'd0);
    check_output("rew_eof", 32'(bus.eof), 32'd0);
    check_output("rew_state", 32'(dut.state_q), 32'(READY));
    read_byte("rew_read", 8'h11, 14'd1, 1'b0);

    $display("[TB] back-to-back requests");
    bus.rewind = 1'b1;
    tick(1);
    bus.rewind = 1'b0;
    vc_before  = valid_count;
    bus.rd_req = 1'b1;
    tick(3);
    bus.rd_req = 1'b0;
    tick(4);
    check_output("hs_valid_count", 32'(valid_count - vc_before), 32'd1);
    check_output("hs_data", 32'(bus.rd_data), 32'h11);
    check_output("hs_rc", 32'(bus.read_counter), 32'd1);

    $display("[TB] rewind with simultaneous request");
    vc_before  = valid_count;
    bus.rewind = 1'b1;
    bus.rd_req = 1'b1;
    tick(1);
    bus.rewind = 1'b0;
    bus.rd_req = 1'b0;
    tick(4);
    check_output("rr_valid_count", 32'(valid_count - vc_before), 32'd0);
    check_output("rr_rc", 32'(bus.read_counter), 32'd0);

    $display("[TB] abort during WAIT");
    vc_before  = valid_count;
    bus.rd_req = 1'b1;
    tick(1);
    bus.rd_req = 1'b0;
    tick(1);
    check_output("abort_in_wait", 32'(dut.state_q), 32'(WAIT));
    bus.ioctl_download = 1'b1;
    tick(1);
    check_output("abort_valid", 32'(bus.rd_valid), 32'd0);
    check_output("abort_state", 32'(dut.state_q), 32'(LOAD));
    check_output("abort_addr_max", 32'(bus.addr_max), 32'd0);
    check_output("abort_active", 32'(bus.download_active), 32'd1);
    tick(3);
    check_output("abort_valid_count", 32'(valid_count - vc_before), 32'd0);
    bus.ioctl_download = 1'b0;
    tick(1);
    check_output("abort_empty_state", 32'(dut.state_q), 32'(IDLE));
    check_output("abort_empty_active", 32'(bus.download_active), 32'd0);
    read_byte("idle_read", 8'h00, 14'd0, 1'b0);

    $display("[TB] stray write outside LOAD");
    load_image(4);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 14'd5;
    bus.ioctl_dout = 8'h99;
    tick(1);
    bus.ioctl_addr = 14'd0;
    tick(1);
    bus.ioctl_wr   = 1'b0;
    check_output("stray_addr_max", 32'(bus.addr_max), 32'd3);
    read_byte("stray_read", 8'h11, 14'd1, 1'b0);

    $display("[TB] reset mid-load");
    bus.ioctl_download = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 14'(i);
      bus.ioctl_dout = 8'h5A;
      tick(1);
    end
    bus.ioctl_wr = 1'b0;
    check_output("ml_addr_max", 32'(bus.addr_max), 32'd2);
    resetn             = 1'b0;
    bus.ioctl_download = 1'b0;
    tick(1);
    check_output("ml_state", 32'(dut.state_q), 32'(IDLE));
    check_output("ml_addr_max_rst", 32'(bus.addr_max), 32'd0);
    check_output("ml_rc", 32'(bus.read_counter), 32'd0);
    check_output("ml_rd_data", 32'(bus.rd_data), 32'd0);
    check_output("ml_eof", 32'(bus.eof), 32'd0);
    check_output("ml_active", 32'(bus.download_active), 32'd0);
    resetn = 1'b1;
    tick(1);

    $display("[TB] empty download window");
    bus.ioctl_download = 1'b1;
    tick(1);
    check_output("empty_load_active", 32'(bus.download_active), 32'd1);
    bus.ioctl_download = 1'b0;
    tick(1);
    check_output("empty_state", 32'(dut.state_q), 32'(IDLE));
    check_output("empty_active", 32'(bus.download_active), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
